// File: rtl/can_crc_ctrl_if.sv
// Bit-level handshake between the CAN bit-timing/stuffing logic, the frame FSMs
// and the CRC-15 sequencer.
interface can_crc_ctrl_if #(
    parameter int CNT_W = 7
);
    logic             start;
    logic             mode;
    logic [CNT_W-1:0] nbits;
    logic             bit_en;
    logic             bit_in;
    logic             stuff;
    logic             busy;
    logic             crc_phase;
    logic             crc_bit;
    logic [14:0]      crc_val;
    logic             done;
    logic             crc_err;

    modport master (
        output start, mode, nbits, bit_en, bit_in, stuff,
        input  busy, crc_phase, crc_bit, crc_val, done, crc_err
    );

    modport slave (
        input  start, mode, nbits, bit_en, bit_in, stuff,
        output busy, crc_phase, crc_bit, crc_val, done, crc_err
    );
endinterface

// File: rtl/can_crc_ctrl.sv
// CAN CRC-15 sequencer: accumulates the covered frame bits, then serialises (TX)
// or checks (RX) the 15-bit CRC field. Stuff bits are ignored throughout.
module can_crc_ctrl #(
    parameter int          CNT_W = 7,
    parameter logic [14:0] POLY  = 15'h4599
) (
    input  logic           clk,
    input  logic           rst_n,
    can_crc_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

    state_t           state;
    logic [14:0]      crc;
    logic [14:0]      shift;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       k;
    logic             mode_q;
    logic [14:0]      crc_val;
    logic             busy;
    logic             crc_phase;
    logic             done;
    logic             crc_err;

    logic             accepted;
    logic [14:0]      crc_next;

    assign accepted = bus.bit_en & ~bus.stuff;
    assign crc_next = {crc[13:0], 1'b0} ^ ((bus.bit_in ^ crc[14]) ? POLY : 15'h0000);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            crc       <= '0;
            shift     <= '0;
            cnt       <= '0;
            k         <= '0;
            mode_q    <= 1'b0;
            crc_val   <= '0;
            busy      <= 1'b0;
            crc_phase <= 1'b0;
            done      <= 1'b0;
            crc_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            // NOTE: start is decoded ahead of the state case so it wins over a same-cycle bit_en.
            if (bus.start) begin
                mode_q  <= bus.mode;
                cnt     <= bus.nbits;
                crc     <= '0;
                shift   <= '0;
                k       <= '0;
                crc_val <= '0;
                crc_err <= 1'b0;
                busy    <= 1'b1;
                if (bus.nbits == '0) begin
                    state     <= CRC;
                    crc_phase <= 1'b1;
                end else begin
                    state     <= DATA;
                    crc_phase <= 1'b0;
                end
            end else begin
                case (state)
                    DATA: begin
                        if (accepted) begin
                            crc <= crc_next;
                            cnt <= cnt - 1'b1;
                            if (cnt == CNT_W'(1)) begin
                                crc_val   <= crc_next;
                                shift     <= crc_next;
                                k         <= '0;
                                state     <= CRC;
                                crc_phase <= 1'b1;
                            end
                        end
                    end
                    CRC: begin
                        if (accepted) begin
                            shift <= {shift[13:0], 1'b0};
                            k     <= k + 4'd1;
                            if (mode_q && (bus.bit_in != shift[14]))
                                crc_err <= 1'b1;
                            if (k == 4'd14) begin
                                done      <= 1'b1;
                                state     <= IDLE;
                                busy      <= 1'b0;
                                crc_phase <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Only a transmitter in the CRC field drives a checksum bit.
    assign bus.crc_bit   = crc_phase & ~mode_q & shift[14];
    assign bus.busy      = busy;
    assign bus.crc_phase = crc_phase;
    assign bus.crc_val   = crc_val;
    assign bus.done      = done;
    assign bus.crc_err   = crc_err;
endmodule

// File: tb/tb_can_crc_ctrl.sv
// Self-checking bench for can_crc_ctrl; expected CRCs come from polynomial long
// division of the covered message by the CAN generator.
module tb_can_crc_ctrl;
    localparam int CNT_W = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    can_crc_ctrl_if #(.CNT_W(CNT_W)) bus ();

    can_crc_ctrl #(.CNT_W(CNT_W), .POLY(15'h4599)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int done_total = 0;

    always @(negedge clk) if (bus.done === 1'b1) done_total++;

    typedef struct {
        logic        busy_start;
        logic        err_start;
        logic        phase_entry;
        logic [14:0] val_entry;
        logic [14:0] tx_bits;
        logic        done_end;
        logic        busy_end;
        logic        phase_end;
        logic        err_end;
        int          done_cnt;
        logic        err_after;
    } obs_t;

    // Remainder of M(x)*x^15 divided by x^15 + POLY, message MSB first.
    function automatic logic [14:0] ref_crc(input bit data[$]);
        bit          m[$];
        logic [15:0] g;
        logic [14:0] r;
        g = 16'hC599;
        m = data;
        for (int i = 0; i < 15; i++) m.push_back(1'b0);
        for (int i = 0; i < data.size(); i++)
            if (m[i]) for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ g[15-j];
        r = '0;
        for (int j = 0; j < 15; j++) r[14-j] = m[data.size()+j];
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.start  = 1'b0;
        bus.mode   = 1'b0;
        bus.nbits  = '0;
        bus.bit_en = 1'b0;
        bus.bit_in = 1'b0;
        bus.stuff  = 1'b0;
    endtask

    // Optional stuff bit and idle gap, then one real bit; crc_bit seen just before it.
    task automatic send_bit(input bit b, input int stuff_pct, input int gap_pct, output logic seen);
        if ($urandom_range(99) < stuff_pct) begin
            bus.bit_en = 1'b1; bus.stuff = 1'b1; bus.bit_in = 1'($urandom);
            tick();
        end
        if ($urandom_range(99) < gap_pct) begin
            bus.bit_en = 1'b0; bus.stuff = 1'b0; bus.bit_in = 1'($urandom);
            tick();
        end
        seen = bus.crc_bit;
        bus.bit_en = 1'b1; bus.stuff = 1'b0; bus.bit_in = b;
        tick();
        bus.bit_en = 1'b0;
    endtask

    task automatic run_frame(input bit md, input bit data[$], input bit flip7, input int stuff_pct,
                             input int gap_pct, input bit start_with_en, output obs_t o);
        logic [14:0] exp;
        logic        seen;
        int          d0;
        exp = ref_crc(data);
        d0  = done_total;
        bus.start  = 1'b1;
        bus.mode   = md;
        bus.nbits  = CNT_W'(data.size());
        bus.bit_en = start_with_en;
        bus.bit_in = 1'($urandom);
        bus.stuff  = 1'b0;
        tick();
        o.busy_start = bus.busy;
        o.err_start  = bus.crc_err;
        bus.start  = 1'b0;
        bus.mode   = ~md;
        bus.nbits  = CNT_W'($urandom);
        bus.bit_en = 1'b0;
        foreach (data[i]) send_bit(data[i], stuff_pct, gap_pct, seen);
        o.phase_entry = bus.crc_phase;
        o.val_entry   = bus.crc_val;
        for (int k = 0; k < 15; k++) begin
            send_bit(exp[14-k] ^ (flip7 && k == 6), stuff_pct, gap_pct, seen);
            o.tx_bits[14-k] = seen;
        end
        o.done_end  = bus.done;
        o.busy_end  = bus.busy;
        o.phase_end = bus.crc_phase;
        o.err_end   = bus.crc_err;
        tick();
        tick();
        o.err_after = bus.crc_err;
        o.done_cnt  = done_total - d0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_vec++; if (bus.crc_phase !== 1'b0) begin n_err++; $display("FAIL reset_crc_phase got=%b exp=0", bus.crc_phase); end
        n_vec++; if (bus.crc_bit !== 1'b0) begin n_err++; $display("FAIL reset_crc_bit got=%b exp=0", bus.crc_bit); end
        n_vec++; if (bus.crc_val !== 15'h0) begin n_err++; $display("FAIL reset_crc_val got=%h exp=0", bus.crc_val); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_vec++; if (bus.crc_err !== 1'b0) begin n_err++; $display("FAIL reset_crc_err got=%b exp=0", bus.crc_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_tx_single();
        bit   d[$];
        obs_t o;
        d.push_back(1'b1);
        run_frame(1'b0, d, 1'b0, 0, 0, 1'b0, o);
        n_vec++; if (o.busy_start !== 1'b1) begin n_err++; $display("FAIL tx1_busy_after_start got=%b exp=1", o.busy_start); end
        n_vec++; if (o.phase_entry !== 1'b1) begin n_err++; $display("FAIL tx1_crc_phase_entry got=%b exp=1", o.phase_entry); end
        n_vec++; if (o.val_entry !== 15'h4599) begin n_err++; $display("FAIL tx1_crc_val got=%h exp=4599", o.val_entry); end
        n_vec++; if (o.tx_bits !== 15'h4599) begin n_err++; $display("FAIL tx1_crc_bits got=%h exp=4599", o.tx_bits); end
        n_vec++; if (o.done_end !== 1'b1 || o.done_cnt != 1) begin n_err++; $display("FAIL tx1_done got=%b/%0d exp=1/1", o.done_end, o.done_cnt); end
        n_vec++; if (o.busy_end !== 1'b0 || o.phase_end !== 1'b0) begin n_err++; $display("FAIL tx1_busy_phase_at_done got=%b%b exp=00", o.busy_end, o.phase_end); end
        n_vec++; if (o.err_end !== 1'b0) begin n_err++; $display("FAIL tx1_crc_err got=%b exp=0", o.err_end); end
    endtask

    task automatic test_rx_check();
        bit   d[$];
        obs_t o;
        d.push_back(1'b1); d.push_back(1'b0);
        run_frame(1'b1, d, 1'b0, 0, 0, 1'b0, o);
        n_vec++; if (o.val_entry !== 15'h4EAB) begin n_err++; $display("FAIL rx_crc_val got=%h exp=4eab", o.val_entry); end
        n_vec++; if (o.err_end !== 1'b0) begin n_err++; $display("FAIL rx_good_crc_err got=%b exp=0", o.err_end); end
        n_vec++; if (o.tx_bits !== 15'h0) begin n_err++; $display("FAIL rx_crc_bit_driven got=%h exp=0", o.tx_bits); end
        run_frame(1'b1, d, 1'b1, 0, 0, 1'b0, o);
        n_vec++; if (o.err_end !== 1'b1) begin n_err++; $display("FAIL rx_bad_crc_err got=%b exp=1", o.err_end); end
        n_vec++; if (o.err_after !== 1'b1) begin n_err++; $display("FAIL rx_bad_crc_err_held got=%b exp=1", o.err_after); end
        run_frame(1'b1, d, 1'b0, 0, 0, 1'b0, o);
        n_vec++; if (o.err_start !== 1'b0) begin n_err++; $display("FAIL rx_err_cleared_by_start got=%b exp=0", o.err_start); end
        n_vec++; if (o.err_end !== 1'b0) begin n_err++; $display("FAIL rx_rerun_crc_err got=%b exp=0", o.err_end); end
    endtask

    task automatic test_stuff_skip();
        bit   d[$];
        obs_t o;
        d.push_back(1'b1); d.push_back(1'b0);
        run_frame(1'b0, d, 1'b0, 100, 0, 1'b0, o);
        n_vec++; if (o.val_entry !== 15'h4EAB) begin n_err++; $display("FAIL stuff_crc_val got=%h exp=4eab", o.val_entry); end
        n_vec++; if (o.tx_bits !== 15'h4EAB) begin n_err++; $display("FAIL stuff_crc_bits got=%h exp=4eab", o.tx_bits); end
        n_vec++; if (o.done_end !== 1'b1 || o.done_cnt != 1) begin n_err++; $display("FAIL stuff_done got=%b/%0d exp=1/1", o.done_end, o.done_cnt); end
        run_frame(1'b1, d, 1'b0, 100, 0, 1'b0, o);
        n_vec++; if (o.err_end !== 1'b0) begin n_err++; $display("FAIL stuff_rx_crc_err got=%b exp=0", o.err_end); end
    endtask

    task automatic test_zero_frames();
        bit   d[$];
        obs_t o;
        run_frame(1'b0, d, 1'b0, 0, 0, 1'b0, o);
        n_vec++; if (o.phase_entry !== 1'b1) begin n_err++; $display("FAIL nbits0_crc_phase got=%b exp=1", o.phase_entry); end
        n_vec++; if (o.val_entry !== 15'h0) begin n_err++; $display("FAIL nbits0_crc_val got=%h exp=0", o.val_entry); end
        n_vec++; if (o.done_cnt != 1) begin n_err++; $display("FAIL nbits0_done_count got=%0d exp=1", o.done_cnt); end
        for (int i = 0; i < 4; i++) d.push_back(1'b0);
        run_frame(1'b0, d, 1'b0, 0, 0, 1'b0, o);
        n_vec++; if (o.val_entry !== 15'h0) begin n_err++; $display("FAIL zeros_crc_val got=%h exp=0", o.val_entry); end
        n_vec++; if (o.tx_bits !== 15'h0) begin n_err++; $display("FAIL zeros_crc_bits got=%h exp=0", o.tx_bits); end
    endtask

    task automatic test_restart();
        bit   d[$];
        obs_t o;
        logic seen;
        bus.start = 1'b1; bus.mode = 1'b0; bus.nbits = CNT_W'(10); bus.bit_en = 1'b0; bus.stuff = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'($urandom), 0, 0, seen);
        for (int i = 0; i < 6; i++) d.push_back(1'($urandom));
        run_frame(1'b0, d, 1'b0, 0, 0, 1'b1, o);
        n_vec++; if (o.val_entry !== ref_crc(d)) begin n_err++; $display("FAIL restart_crc_val got=%h exp=%h", o.val_entry, ref_crc(d)); end
        n_vec++; if (o.tx_bits !== ref_crc(d)) begin n_err++; $display("FAIL restart_crc_bits got=%h exp=%h", o.tx_bits, ref_crc(d)); end
        n_vec++; if (o.done_cnt != 1) begin n_err++; $display("FAIL restart_done_count got=%0d exp=1", o.done_cnt); end
    endtask

    task automatic test_reset_mid_crc();
        bit   d[$];
        obs_t o;
        logic seen;
        int   d0;
        d.push_back(1'b1); d.push_back(1'b1); d.push_back(1'b0);
        d0 = done_total;
        bus.start = 1'b1; bus.mode = 1'b0; bus.nbits = CNT_W'(3); bus.bit_en = 1'b0; bus.stuff = 1'b0;
        tick();
        bus.start = 1'b0;
        foreach (d[i]) send_bit(d[i], 0, 0, seen);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 0, 0, seen);
        rst_n = 1'b0; bus.bit_en = 1'b1; bus.bit_in = 1'b1;
        tick();
        n_vec++; if (bus.busy !== 1'b0 || bus.crc_phase !== 1'b0) begin n_err++; $display("FAIL midreset_busy_phase got=%b%b exp=00", bus.busy, bus.crc_phase); end
        n_vec++; if (bus.crc_val !== 15'h0 || bus.crc_bit !== 1'b0) begin n_err++; $display("FAIL midreset_crc got=%h/%b exp=0/0", bus.crc_val, bus.crc_bit); end
        rst_n = 1'b1; bus.bit_en = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        n_vec++; if (done_total != d0) begin n_err++; $display("FAIL midreset_no_done got=%0d exp=0", done_total - d0); end
        run_frame(1'b0, d, 1'b0, 0, 0, 1'b0, o);
        n_vec++; if (o.val_entry !== ref_crc(d)) begin n_err++; $display("FAIL midreset_next_crc_val got=%h exp=%h", o.val_entry, ref_crc(d)); end
        n_vec++; if (o.done_cnt != 1) begin n_err++; $display("FAIL midreset_next_done got=%0d exp=1", o.done_cnt); end
    endtask

    task automatic test_random();
        bit          d[$];
        obs_t        o;
        bit          md;
        bit          flip;
        logic [14:0] exp;
        for (int f = 0; f < 24; f++) begin
            d.delete();
            md   = 1'($urandom);
            flip = md & 1'($urandom);
            for (int i = 0; i < int'($urandom_range(30)); i++) d.push_back(1'($urandom));
            exp = ref_crc(d);
            run_frame(md, d, flip, 15, 20, 1'b0, o);
            n_vec++; if (o.val_entry !== exp) begin n_err++; $display("FAIL rand%0d_crc_val got=%h exp=%h", f, o.val_entry, exp); end
            n_vec++; if (o.tx_bits !== (md ? 15'h0 : exp)) begin n_err++; $display("FAIL rand%0d_crc_bits got=%h exp=%h", f, o.tx_bits, md ? 15'h0 : exp); end
            n_vec++; if (o.err_end !== flip) begin n_err++; $display("FAIL rand%0d_crc_err got=%b exp=%b", f, o.err_end, flip); end
            n_vec++; if (o.done_end !== 1'b1 || o.done_cnt != 1) begin n_err++; $display("FAIL rand%0d_done got=%b/%0d exp=1/1", f, o.done_end, o.done_cnt); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_tx_single();
        test_rx_check();
        test_stuff_skip();
        test_zero_frames();
        test_restart();
        test_reset_mid_crc();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
